// File: rtl/mar_pkg.sv
// mar_pkg: shared definitions for the burst-capable memory address register.
//   MarState            : FSM states (IDLE, REQ)
//   MAR_ADDR_W_DEFAULT  : default address width
//   MAR_LEN_W_DEFAULT   : default burst length field width
//   maxBurstLen()       : largest burst a LEN_W-bit length field can express
package mar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } MarState;

  localparam int MAR_ADDR_W_DEFAULT = 4;
  localparam int MAR_LEN_W_DEFAULT  = 4;

  // A zero length is rejected at burst_start, so the longest burst is all-ones.
  function automatic int maxBurstLen(input int lenW);
    return (1 << lenW) - 1;
  endfunction

endpackage

// File: rtl/mar_burst_cnt.sv
// mar_burst_cnt: down-counter tracking how many beats of a burst remain.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   load      in   capture value as the new beat count
//   dec       in   one beat was accepted, count down by one
//   value     in   LEN_W  beat count to load
//   remaining out  LEN_W  beats still outstanding
//   last      out  the beat currently offered is the final one
module mar_burst_cnt #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [LEN_W-1:0] value,
  output logic [LEN_W-1:0] remaining,
  output logic             last
);

  logic [LEN_W-1:0] r_remaining;

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (load) begin
      r_remaining <= value;
    end else if (dec && (r_remaining != '0)) begin
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign remaining = r_remaining;
  assign last      = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/mar_burst.sv
// mar_burst: memory address register with valid flag, single-step increment
// and an autonomous req/ack burst engine driving the RAM address port.
//   clk, rst     clock and asynchronous active-high reset
//   load         capture load_addr (ADDR_W) into the address register
//   inc          step the address by one (IDLE only, needs a valid address)
//   burst_start  start a burst_len (LEN_W) beat burst at the current address
//   mem_ack      RAM accepted the beat currently offered
//   addr         current address; addr_valid marks it as loaded
//   mem_req      beat request to RAM; busy mirrors it
//   burst_done   one-cycle pulse after the final beat
//   wrap_err     sticky address wrap flag, only when MAR_WRAP_ERR_EN is defined
module mar_burst
  import mar_pkg::*;
#(
  parameter int ADDR_W = MAR_ADDR_W_DEFAULT,
  parameter int LEN_W  = MAR_LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  input  logic              burst_start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              mem_req,
  output logic              busy,
  output logic              burst_done,
  output logic              wrap_err
);

  MarState           r_state;
  MarState           w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addrValid;
  logic              r_burstDone;
  logic              w_take;
  logic              w_step;
  logic              w_doneNext;
  logic              w_cntLoad;
  logic              w_cntDec;
  logic [LEN_W-1:0]  w_remaining;
  logic              w_last;

  mar_burst_cnt #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cntLoad),
    .dec      (w_cntDec),
    .value    (burst_len),
    .remaining(w_remaining),
    .last     (w_last)
  );

  // Command decode. w_take means a load is accepted, w_step means the address
  // advances by one (inc or an acked beat). Only one command acts per cycle.
  always_comb begin
    w_nextState = r_state;
    w_take      = 1'b0;
    w_step      = 1'b0;
    w_doneNext  = 1'b0;
    w_cntLoad   = 1'b0;
    w_cntDec    = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_take = 1'b1;
        end else if (burst_start && r_addrValid && (burst_len != '0)) begin
          w_cntLoad   = 1'b1;
          w_nextState = REQ;
        end else if (inc && r_addrValid) begin
          w_step = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack && (w_remaining != '0)) begin
          w_step   = 1'b1;
          w_cntDec = 1'b1;
          if (w_last) begin
            w_nextState = IDLE;
            w_doneNext  = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_addrValid <= 1'b0;
      r_burstDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_burstDone <= w_doneNext;
      if (w_take) begin
        r_addr      <= load_addr;
        r_addrValid <= 1'b1;
      end else if (w_step) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

`ifdef MAR_WRAP_ERR_EN
  logic r_wrapErr;

  // Any step from the all-ones address wraps to zero and latches the flag
  // until the next accepted load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrapErr <= 1'b0;
    end else if (w_take) begin
      r_wrapErr <= 1'b0;
    end else if (w_step && (r_addr == '1)) begin
      r_wrapErr <= 1'b1;
    end
  end

  assign wrap_err = r_wrapErr;
`else
  assign wrap_err = 1'b0;
`endif

  assign addr       = r_addr;
  assign addr_valid = r_addrValid;
  assign mem_req    = (r_state == REQ);
  assign busy       = (r_state == REQ);
  assign burst_done = r_burstDone;

endmodule

// File: tb/tb_mar_burst.sv
// tb_mar_burst: directed bench for mar_burst with a queue-based reference
// model compared every cycle, plus literal expectations at key points.
module tb_mar_burst;

  localparam int AW   = 4;
  localparam int LW   = 4;
  localparam int AMOD = 1 << AW;
`ifdef MAR_WRAP_ERR_EN
  localparam int WRAP_EN = 1;
`else
  localparam int WRAP_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [AW-1:0] load_addr;
  logic          inc;
  logic          burst_start;
  logic [LW-1:0] burst_len;
  logic          mem_ack;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          mem_req;
  logic          busy;
  logic          burst_done;
  logic          wrap_err;

  int checks   = 0;
  int failures = 0;
  bit compareOn = 1'b0;

  // Reference model: the address, validity, a queue of addresses still to be
  // issued in the current burst, the done pulse and the sticky wrap flag.
  int mAddr  = 0;
  bit mValid = 1'b0;
  bit mDone  = 1'b0;
  bit mWrap  = 1'b0;
  int mQ[$];

  mar_burst #(
    .ADDR_W(AW),
    .LEN_W (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_addr  (load_addr),
    .inc        (inc),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .mem_ack    (mem_ack),
    .addr       (addr),
    .addr_valid (addr_valid),
    .mem_req    (mem_req),
    .busy       (busy),
    .burst_done (burst_done),
    .wrap_err   (wrap_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit ld, input int la, input bit in, input bit bs,
                               input int bl, input bit ack);
    load        = ld;
    load_addr   = AW'(la);
    inc         = in;
    burst_start = bs;
    burst_len   = LW'(bl);
    mem_ack     = ack;
    @(posedge clk);
    #1;
  endtask

  // Model update on each rising edge, or immediately on reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mAddr  = 0;
        mValid = 1'b0;
        mDone  = 1'b0;
        mWrap  = 1'b0;
        mQ.delete();
      end else begin
        mDone = 1'b0;
        if (mQ.size() != 0) begin
          if (mem_ack) begin
            if (mAddr == AMOD - 1 && WRAP_EN != 0) mWrap = 1'b1;
            mAddr = (mAddr + 1) % AMOD;
            void'(mQ.pop_front());
            if (mQ.size() == 0) mDone = 1'b1;
          end
        end else if (load) begin
          mAddr  = int'(load_addr);
          mValid = 1'b1;
          mWrap  = 1'b0;
        end else if (burst_start && mValid && burst_len != 0) begin
          for (int i = 0; i < int'(burst_len); i++) mQ.push_back((mAddr + i) % AMOD);
        end else if (inc && mValid) begin
          if (mAddr == AMOD - 1 && WRAP_EN != 0) mWrap = 1'b1;
          mAddr = (mAddr + 1) % AMOD;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (compareOn) begin
        checkOutput("cmp_addr", int'(addr), mAddr);
        checkOutput("cmp_valid", int'(addr_valid), int'(mValid));
        checkOutput("cmp_mem_req", int'(mem_req), int'(mQ.size() != 0));
        checkOutput("cmp_busy", int'(busy), int'(mQ.size() != 0));
        checkOutput("cmp_burst_done", int'(burst_done), int'(mDone));
        checkOutput("cmp_wrap_err", int'(wrap_err), int'(mWrap));
        if (mQ.size() != 0) checkOutput("cmp_beat_addr", int'(addr), mQ[0]);
      end
    end
  end

  // Directed sequence.
  initial begin
    int beats;
    rst = 1'b1;
    load = 1'b0; load_addr = '0; inc = 1'b0; burst_start = 1'b0; burst_len = '0; mem_ack = 1'b0;
    compareOn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_addr", int'(addr), 0);
    checkOutput("rst_valid", int'(addr_valid), 0);
    checkOutput("rst_mem_req", int'(mem_req), 0);
    checkOutput("rst_wrap_err", int'(wrap_err), 0);
    rst = 1'b0;

    // Commands that need a valid address are ignored before any load.
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("inc_invalid_addr", int'(addr), 0);
    applyStimulus(0, 0, 0, 1, 3, 0);
    checkOutput("burst_invalid_req", int'(mem_req), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("burst_invalid_done", int'(burst_done), 0);

    applyStimulus(1, 5, 0, 0, 0, 0);
    checkOutput("load5_addr", int'(addr), 5);
    checkOutput("load5_valid", int'(addr_valid), 1);

    // Wrap through the top of the address space.
    applyStimulus(1, 14, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("inc_addr_f", int'(addr), 15);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("inc_wrap_addr", int'(addr), 0);
    checkOutput("model_wrap_addr", mAddr, 0);
    checkOutput("inc_wrap_flag", int'(wrap_err), WRAP_EN);
    applyStimulus(1, 3, 0, 0, 0, 0);
    checkOutput("load_clears_wrap", int'(wrap_err), 0);

    // Four-beat burst with ack held high (ack while idle is ignored).
    applyStimulus(0, 0, 0, 1, 4, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("burst_beat_addr", int'(addr), 3 + i);
      checkOutput("burst_beat_req", int'(mem_req), 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
    end
    checkOutput("burst_end_req", int'(mem_req), 0);
    checkOutput("burst_end_busy", int'(busy), 0);
    checkOutput("burst_end_done", int'(burst_done), 1);
    checkOutput("burst_end_addr", int'(addr), 7);
    checkOutput("model_end_addr", mAddr, 7);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("done_one_cycle", int'(burst_done), 0);

    // Same burst with ack every other cycle; a load mid-burst must be ignored.
    applyStimulus(1, 3, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 4, 0);
    beats = 0;
    for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
      applyStimulus(cyc == 2, 15, 0, 0, 0, (cyc % 2) == 1);
      if (cyc % 2 == 1) beats++;
    end
    checkOutput("slow_burst_beats", beats, 4);
    checkOutput("slow_burst_done", int'(burst_done), 1);
    checkOutput("slow_burst_addr", int'(addr), 7);
    checkOutput("slow_burst_req", int'(mem_req), 0);

    // Zero-length burst is ignored.
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("len0_req", int'(mem_req), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("len0_done", int'(burst_done), 0);

    // Reset during beat 2 of a five-beat burst.
    applyStimulus(1, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("pre_rst_addr", int'(addr), 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_addr", int'(addr), 0);
    checkOutput("midrst_valid", int'(addr_valid), 0);
    checkOutput("midrst_req", int'(mem_req), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(burst_done), 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_done", int'(burst_done), 0);

    // Normal operation after reset.
    applyStimulus(1, 9, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2, 1);
    checkOutput("post_rst_req", int'(mem_req), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("post_rst_burst_done", int'(burst_done), 1);
    checkOutput("post_rst_burst_addr", int'(addr), 11);
    applyStimulus(0, 0, 0, 0, 0, 0);

    compareOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
